// File: rtl/pc_fetch_unit.sv
// IF stage: PC register with stall/branch/jump redirect plus the IF/ID pipeline register.
// pc_out is registered (redirect visible next cycle); stall holds PC and IF/ID, flush bubbles IF/ID.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        cl,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;
    assign pc_out   = pc;

    // Redirects are ignored while stalled; ID keeps them asserted until the stall drops.
    always_comb begin
        pc_next = pc_plus4;
        if (stall) begin
            pc_next = pc;
        end else if (branch_taken) begin
            pc_next = {branch_target[31:2], 2'b00};
        end else if (jump) begin
            pc_next = {if_id_pc4[31:28], jump_index, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (cl) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Flush outranks stall so a killed instruction never lingers in IF/ID.
    always_ff @(posedge clk) begin
        if (cl || flush) begin
            if_id_instr <= 32'h00000000;
            if_id_pc4   <= 32'h00000000;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= instr_in;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then random traffic vs a reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        cl;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    logic [31:0] key = 32'h0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: contents are the address xor a key (key 0 => instr == address).
    assign instr_in = pc_out ^ key;

    pc_fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .clk           (clk),
        .cl            (cl),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what pc_out / IF/ID must hold after each edge.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    bit          m_known = 0;

    always @(posedge clk) begin
        logic [31:0] npc;
        if (cl) begin
            m_pc = 32'h0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_known = 1;
        end else if (m_known) begin
            if (stall)             npc = m_pc;
            else if (branch_taken) npc = branch_target & 32'hFFFF_FFFC;
            else if (jump)         npc = {m_pc4[31:28], jump_index, 2'b00};
            else                   npc = m_pc + 32'd4;
            if (flush) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = m_pc ^ key; m_pc4 = m_pc + 32'd4; m_valid = 1;
            end
            m_pc = npc;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("cyc_pc_out", pc_out, m_pc);
            chk("cyc_if_id_pc4", if_id_pc4, m_pc4);
            chk("cyc_if_id_instr", if_id_instr, m_instr);
            chk("cyc_if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] ins, input logic vld);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_pc4"}, if_id_pc4, pc4);
        chk({tag, "_instr"}, if_id_instr, ins);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, vld});
    endtask

    initial begin
        cl = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_index = 0;
        cyc(); cyc();
        ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        // Free-running fetch after release
        cl = 0;
        chk("release_pc", pc_out, 32'h0);
        cyc(); ifid("seq1", 32'h4, 32'h4, 32'h0, 1'b1);
        cyc(); ifid("seq2", 32'h8, 32'h8, 32'h4, 1'b1);

        // Two-cycle stall at pc=8
        stall = 1;
        cyc(); cyc(); ifid("stall", 32'h8, 32'h8, 32'h4, 1'b1);
        stall = 0;
        cyc(); ifid("unstall", 32'hC, 32'hC, 32'h8, 1'b1);

        // Branch with misaligned target plus flush
        branch_taken = 1; branch_target = 32'h00000103; flush = 1;
        cyc(); ifid("br", 32'h100, 32'h0, 32'h0, 1'b0);
        chk("model_br_pc", m_pc, 32'h100);
        branch_taken = 0; flush = 0;
        cyc(); ifid("br_tgt", 32'h104, 32'h104, 32'h100, 1'b1);

        // Jump uses the upper nibble of if_id_pc4
        branch_taken = 1; branch_target = 32'h40000004; flush = 1;
        cyc();
        branch_taken = 0; flush = 0;
        cyc(); chk("pre_jump_pc4", if_id_pc4, 32'h40000008);
        jump = 1; jump_index = 26'h0000040; flush = 1;
        cyc(); chk("jump_pc", pc_out, 32'h40000100);
        chk("model_jump_pc", m_pc, 32'h40000100);
        branch_taken = 1; branch_target = 32'h00000200;
        cyc(); chk("br_over_jump_pc", pc_out, 32'h200);
        branch_taken = 0; jump = 0; flush = 0;

        // stall + flush + branch: PC holds, IF/ID bubbles, branch lands once stall drops
        stall = 1; flush = 1; branch_taken = 1; branch_target = 32'h00000300;
        cyc(); ifid("sfb", 32'h200, 32'h0, 32'h0, 1'b0);
        stall = 0;
        cyc(); chk("sfb_release_pc", pc_out, 32'h300);
        branch_taken = 0; flush = 0;

        // Wrap-around at the top of the address space
        branch_taken = 1; branch_target = 32'hFFFFFFFF; flush = 1;
        cyc(); chk("wrap_pre_pc", pc_out, 32'hFFFFFFFC);
        branch_taken = 0; flush = 0;
        cyc(); ifid("wrap", 32'h0, 32'h0, 32'hFFFFFFFC, 1'b1);

        // Reset during the wrap cycle, with stall and jump pending
        branch_taken = 1; branch_target = 32'hFFFFFFFC; flush = 1;
        cyc();
        branch_taken = 0; flush = 0;
        cyc();
        cl = 1; stall = 1; jump = 1;
        cyc(); ifid("wrap_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        cl = 0; stall = 0; jump = 0;
        cyc(); ifid("post_rst", 32'h4, 32'h4, 32'h0, 1'b1);

        // Random traffic against the model
        key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            cl            = ($urandom_range(0, 63) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            jump_index    = 26'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
